// File: rtl/user_bufgmux_ctrl_spec.sv
// Glitch-free two-source clock multiplexer.
// Each source gates itself on its own falling edge, interlocked through synchronized copies of the other enable.
module user_bufgmux_ctrl_spec #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic aclk_in1,
    input  logic aclk_in2,
    input  logic areset,
    input  logic selection,
    output logic aclk_out,
    output logic clk1_active,
    output logic clk2_active
);

    // Domain 1 samples the inverted selection, so a reset value of 0 in
    // either chain means "not requested" and neither source can pre-empt the
    // other right after reset.
    logic [SYNC_STAGES-1:0] sel1_q, sel1_d;
    logic [SYNC_STAGES-1:0] en2s1_q, en2s1_d;
    logic [SYNC_STAGES-1:0] sel2_q, sel2_d;
    logic [SYNC_STAGES-1:0] en1s2_q, en1s2_d;
    logic                   en1_q, en1_d;
    logic                   en2_q, en2_d;

    always_comb begin
        sel1_d  = {sel1_q[SYNC_STAGES-2:0], ~selection};
        en2s1_d = {en2s1_q[SYNC_STAGES-2:0], en2_q};
        en1_d   = sel1_q[SYNC_STAGES-1] & ~en2s1_q[SYNC_STAGES-1];
    end

    always_comb begin
        sel2_d  = {sel2_q[SYNC_STAGES-2:0], selection};
        en1s2_d = {en1s2_q[SYNC_STAGES-2:0], en1_q};
        en2_d   = sel2_q[SYNC_STAGES-1] & ~en1s2_q[SYNC_STAGES-1];
    end

    always_ff @(negedge aclk_in1 or posedge areset) begin
        if (areset) begin
            sel1_q  <= '0;
            en2s1_q <= '0;
            en1_q   <= 1'b0;
        end else begin
            sel1_q  <= sel1_d;
            en2s1_q <= en2s1_d;
            en1_q   <= en1_d;
        end
    end

    always_ff @(negedge aclk_in2 or posedge areset) begin
        if (areset) begin
            sel2_q  <= '0;
            en1s2_q <= '0;
            en2_q   <= 1'b0;
        end else begin
            sel2_q  <= sel2_d;
            en1s2_q <= en1s2_d;
            en2_q   <= en2_d;
        end
    end

    assign aclk_out    = (aclk_in1 & en1_q) | (aclk_in2 & en2_q);
    assign clk1_active = en1_q;
    assign clk2_active = en2_q;

endmodule

// File: tb/tb_user_bufgmux_ctrl_spec.sv
// Bench for the glitch-free clock mux: scoreboard of enable-state changes plus
// continuous pulse-width and mutual-exclusion monitors.
`timescale 1ns/1ps
module tb_user_bufgmux_ctrl_spec;

    logic aclk_in1, aclk_in2, areset, selection;
    logic aclk_out, clk1_active, clk2_active;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_e;
    int         out_rises = 0;
    real        last_edge = 0.0;
    bit         rise_flag;
    real        rise_t;

    user_bufgmux_ctrl_spec #(.SYNC_STAGES(2)) dut (
        .aclk_in1   (aclk_in1),
        .aclk_in2   (aclk_in2),
        .areset     (areset),
        .selection  (selection),
        .aclk_out   (aclk_out),
        .clk1_active(clk1_active),
        .clk2_active(clk2_active)
    );

    initial begin aclk_in1 = 1'b0; forever #10   aclk_in1 = ~aclk_in1; end
    initial begin aclk_in2 = 1'b0; forever #6.67 aclk_in2 = ~aclk_in2; end

    always @(posedge aclk_out) out_rises++;

    // Minimum pulse width on the muxed clock; edges caused by reset are exempt.
    always @(aclk_out) begin
        if (!areset && last_edge > 0.0) begin
            tests++;
            if ($realtime - last_edge < 6.6) begin
                fails++;
                $display("FAIL pulse_width: width=%0.3f ns required>=6.6 ns at %0t", $realtime - last_edge, $time);
            end
        end
        last_edge = $realtime;
    end

    always @(clk1_active or clk2_active) begin
        tests++;
        if (clk1_active && clk2_active) begin
            fails++;
            $display("FAIL mutex: clk1_active=%b clk2_active=%b required not both 1 at %0t", clk1_active, clk2_active, $time);
        end
    end

    // Scoreboard monitor: every change of the enable pair must match the next queued expectation.
    initial begin
        #1;
        forever begin
            @(clk1_active or clk2_active);
            #0.1;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: active=%b required no change at %0t", {clk1_active, clk2_active}, $time);
            end else begin
                exp_e = exp_q.pop_front();
                if ({clk1_active, clk2_active} !== exp_e) begin
                    fails++;
                    $display("FAIL sb_state: active=%b required %b at %0t", {clk1_active, clk2_active}, exp_e, $time);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded 50 us");
        $fatal(1, "watchdog");
    end

    task check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task check_le(input string name, input real act, input real lim);
        tests++;
        if (act > lim) begin
            fails++;
            $display("FAIL %s: got %0.3f required <= %0.3f", name, act, lim);
        end
    endtask

    task wait_out_rise();
        logic prev;
        rise_flag = 1'b0;
        prev = aclk_out;
        for (int i = 0; i < 20000; i++) begin
            #0.01;
            if (!prev && aclk_out) begin
                rise_flag = 1'b1;
                rise_t = $realtime;
                break;
            end
            prev = aclk_out;
        end
    endtask

    task check_period(input string name, input real exp_p);
        real t1, d;
        bit  ok1;
        wait_out_rise();
        ok1 = rise_flag;
        t1  = rise_t;
        wait_out_rise();
        d = rise_t - t1;
        tests++;
        if (!ok1 || !rise_flag || d - exp_p > 0.05 || exp_p - d > 0.05) begin
            fails++;
            $display("FAIL %s: period=%0.3f ns (edges seen %0b%0b) required %0.3f ns", name, d, ok1, rise_flag, exp_p);
        end
    endtask

    // Counts falling edges of the chosen source until the chosen enable reaches want.
    task edges_until(input bit use_clk2, input bit which_en2, input bit want, output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (use_clk2) @(negedge aclk_in2); else @(negedge aclk_in1);
            #0.1;
            n++;
            if ((which_en2 ? clk2_active : clk1_active) == want) break;
        end
    endtask

    task poll_until(input bit which_en2, input bit want, input real limit, output real waited);
        waited = 0.0;
        for (int i = 0; i < 4000; i++) begin
            if ((which_en2 ? clk2_active : clk1_active) == want) break;
            #0.1;
            waited += 0.1;
            if (waited > limit) break;
        end
    endtask

    initial begin
        int  n, r0;
        real t0, w;

        areset    = 1'b1;
        selection = 1'b0;

        // Reset holds everything low.
        repeat (6) begin
            #3.3;
            check("rst_out", aclk_out, 0);
            check("rst_active", {clk1_active, clk2_active}, 0);
        end

        // Release with selection=0: clk1 takes over on its third falling edge.
        @(posedge aclk_in1);
        #2;
        areset = 1'b0;
        t0 = $realtime;
        exp_q.push_back(2'b10);
        edges_until(1'b0, 1'b0, 1'b1, n);
        check("rel_clk1_edges", n, 3);
        check_le("rel_clk1_time", $realtime - t0, 60.0);
        check("rel_clk2_off", clk2_active, 0);
        check_period("period_clk1", 20.0);

        // Switch 0->1.
        #1000;
        @(negedge aclk_in1);
        #19;
        selection = 1'b1;
        t0 = $realtime;
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        edges_until(1'b0, 1'b0, 1'b0, n);
        check("sw01_en1_edges", n, 3);
        r0 = out_rises;
        poll_until(1'b1, 1'b1, 200.0, w);
        check("sw01_gap_low", out_rises - r0, 0);
        check("sw01_clk2_on", clk2_active, 1);
        check_le("sw01_time", $realtime - t0, 100.0);
        check_period("period_clk2", 13.34);

        // Switch 1->0.
        #1000;
        @(negedge aclk_in2);
        #12.3;
        selection = 1'b0;
        t0 = $realtime;
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        edges_until(1'b1, 1'b1, 1'b0, n);
        check("sw10_en2_edges", n, 3);
        r0 = out_rises;
        poll_until(1'b0, 1'b1, 200.0, w);
        check("sw10_gap_low", out_rises - r0, 0);
        check("sw10_clk1_on", clk1_active, 1);
        check_le("sw10_time", $realtime - t0, 100.0);
        check_period("period_clk1_back", 20.0);

        // Burst ending on 0, placed between clk1 samples: no change at all.
        #1000;
        @(negedge aclk_in1);
        for (int i = 0; i < 6; i++) begin
            #1;
            selection = ~selection;
        end
        #1000;
        check("burst0_clk1", clk1_active, 1);
        check("burst0_clk2", clk2_active, 0);
        check_period("burst0_period", 20.0);

        // Burst ending on 1: one clean switch to clk2.
        @(negedge aclk_in1);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        for (int i = 0; i < 5; i++) begin
            #1;
            selection = ~selection;
        end
        poll_until(1'b1, 1'b1, 300.0, w);
        check("burst1_clk2", clk2_active, 1);
        check("burst1_clk1", clk1_active, 0);
        check_period("burst1_period", 13.34);

        // Back to clk1, then reset in the middle of a 0->1 switch.
        #1000;
        selection = 1'b0;
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        poll_until(1'b0, 1'b1, 300.0, w);
        check("pre_rst_clk1", clk1_active, 1);
        #500;
        @(negedge aclk_in1);
        #19;
        selection = 1'b1;
        exp_q.push_back(2'b00);
        edges_until(1'b0, 1'b0, 1'b0, n);
        check("midsw_en1_edges", n, 3);
        #3;
        areset = 1'b1;
        #1;
        check("midsw_rst_out", aclk_out, 0);
        check("midsw_rst_active", {clk1_active, clk2_active}, 0);
        #4;
        check("midsw_rst_out2", aclk_out, 0);
        areset = 1'b0;
        exp_q.push_back(2'b01);
        edges_until(1'b1, 1'b1, 1'b1, n);
        check("midsw_clk2_edges", n, 3);
        check("midsw_clk1_off", clk1_active, 0);
        check_period("midsw_period", 13.34);

        #200;
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
